// File: rtl/generateur_mesure.sv
// Ultrasonic echo emulator: on an accepted start, drives one Mesure pulse of
// NbEff * CYCLES_PER_INCH cycles, framed by a fixed lead-in and trailing gap.
module generateur_mesure #(
  parameter int unsigned CYCLES_PER_INCH = 147,
  parameter int unsigned LEAD_CYCLES     = 16,
  parameter int unsigned GAP_CYCLES      = 64,
  parameter int unsigned NB_MIN          = 6,
  parameter int unsigned NB_MAX          = 254
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [7:0] Nb,
  output logic       Mesure,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] NbEff
);

  localparam logic [15:0] LEAD_LD = 16'(LEAD_CYCLES - 1);
  localparam logic [15:0] GAP_LD  = 16'(GAP_CYCLES - 1);
  localparam logic [7:0]  SUB_LD  = 8'(CYCLES_PER_INCH - 1);
  localparam logic [7:0]  MIN_V   = 8'(NB_MIN);
  localparam logic [7:0]  MAX_V   = 8'(NB_MAX);

  // IDLE wait start | LEAD low lead-in | PULSE echo high | GAP low tail
  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_PULSE, S_GAP} state_t;

  state_t      r_state;
  logic        r_mesure;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_nb_eff;
  logic [7:0]  r_sub;
  logic [7:0]  r_inch;
  logic [15:0] r_cnt;
  logic [7:0]  w_nb_clamped;

  always_comb begin
    w_nb_clamped = Nb;
    if (Nb < MIN_V)
      w_nb_clamped = MIN_V;
    else if (Nb > MAX_V)
      w_nb_clamped = MAX_V;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= S_IDLE;
      r_mesure <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_nb_eff <= 8'd0;
      r_sub    <= 8'd0;
      r_inch   <= 8'd0;
      r_cnt    <= 16'd0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_nb_eff <= w_nb_clamped;
            r_cnt    <= LEAD_LD;
            r_busy   <= 1'b1;
            r_state  <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (r_cnt == 16'd0) begin
            r_sub    <= SUB_LD;
            r_inch   <= r_nb_eff;
            r_mesure <= 1'b1;
            r_state  <= S_PULSE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        S_PULSE: begin
          // r_inch counts inches still to emit, including the current one
          if (r_sub == 8'd0) begin
            if (r_inch <= 8'd1) begin
              r_mesure <= 1'b0;
              r_cnt    <= GAP_LD;
              r_state  <= S_GAP;
            end else begin
              r_inch <= r_inch - 8'd1;
              r_sub  <= SUB_LD;
            end
          end else begin
            r_sub <= r_sub - 8'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == 16'd0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Mesure = r_mesure;
  assign Busy   = r_busy;
  assign Done   = r_done;
  assign NbEff  = r_nb_eff;

endmodule

// File: doc/generateur_mesure.md
# generateur_mesure

Ultrasonic-sensor echo emulator for the rangefinder: on a start request it produces a single active-high echo pulse on `Mesure` whose width encodes a distance in inches at `CYCLES_PER_INCH` clock cycles per inch. It is the transmit end of the echo-width interface. The echo-width counter on the receive side measures the high time and divides by 147, so it must read back exactly the clamped distance. The block drives the receiver in system self-test and in bench loopback, in place of the physical sensor.

## Interface
Parameters:
- `CYCLES_PER_INCH`, 147, clock cycles of `Mesure` high per inch; legal range 2..255.
- `LEAD_CYCLES`, 16, low cycles between start acceptance and the rising edge; legal range 1..65535.
- `GAP_CYCLES`, 64, minimum low cycles after the falling edge before `Done`; legal range 1..65535.
- `NB_MIN`, 6, lower clamp of the distance in inches.
- `NB_MAX`, 254, upper clamp of the distance in inches.

Ports:
- `Clk`  in  1  system clock; all logic on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Start`  in  1  start request; sampled only in IDLE.
- `Nb`  in  8  requested distance in inches; sampled only on start acceptance.
- `Mesure`  out  1  echo pulse, registered.
- `Busy`  out  1  high while a measurement sequence is in progress (LEAD, PULSE, GAP).
- `Done`  out  1  one-cycle pulse when a sequence completes.
- `NbEff`  out  8  clamped distance latched at acceptance; held until the next acceptance.

## Operation
- States: IDLE, LEAD, PULSE, GAP.
- IDLE, with `Start`=1: accept the request.
  - Latch `NbEff` = `NB_MIN` if `Nb` < `NB_MIN`; `NB_MAX` if `Nb` > `NB_MAX`; otherwise `Nb`.
  - Go to LEAD.
- LEAD: `Mesure`=0 for `LEAD_CYCLES` cycles, then go to PULSE.
- PULSE: `Mesure`=1 for exactly `NbEff` × `CYCLES_PER_INCH` cycles, then go to GAP.
  - No multiplier. Use a sub-counter 0..`CYCLES_PER_INCH`−1 and an 8-bit inch down-counter loaded with `NbEff`.
  - Maximum width with defaults: 254 × 147 = 37338 cycles.
- GAP: `Mesure`=0 for `GAP_CYCLES` cycles, then go to IDLE with `Done`=1 for one cycle.
- `Busy`=1 exactly while in LEAD, PULSE or GAP.
- `Start` while `Busy`=1 is ignored; requests are not queued.
- `Nb` changes after acceptance have no effect on the sequence in progress.
- The `Done` cycle is an IDLE cycle, so `Start`=1 in that cycle is accepted (back-to-back operation).
- `Rst`=1, at any time including mid-pulse:
  - Next edge: state IDLE, `Mesure`=0, `Busy`=0, `Done`=0, `NbEff`=0, all counters cleared.
  - No `Done` is issued for the aborted sequence.
  - `Rst` has priority over `Start` in the same cycle.

## Timing
- Reset values: `Mesure`=0, `Busy`=0, `Done`=0, `NbEff`=0.
- `Start` accepted at edge k:
  - `Busy`=1 and `NbEff` valid from cycle k+1.
  - `Mesure`=1 during cycles k+1+L through k+L+N·C, where L = `LEAD_CYCLES`, N = `NbEff`, C = `CYCLES_PER_INCH`.
  - `Mesure`=0 during the gap, cycles k+1+L+N·C through k+L+N·C+G, where G = `GAP_CYCLES`.
  - `Done`=1 and `Busy`=0 in cycle k+1+L+N·C+G.
- Total sequence length: L + N·C + G cycles of `Busy`.
- Minimum `Start`-to-`Start` spacing: L + N·C + G + 1 cycles.
- `Mesure` is glitch-free: it comes directly from a flop and has exactly one rising and one falling edge per sequence.
- Cycle counts are exact, with no ±1 tolerance. The receiver's integer division must return N, not N−1.

## Test plan
- Defaults, `Nb`=10, `Start` pulse at cycle 0 -> `NbEff`=10; `Mesure` high cycles 17..1486 (1470 cycles); `Done` at cycle 1551; `Busy` high cycles 1..1550.
- `Nb`=2, then `Nb`=255 -> `NbEff`=6 with a high time of 882 cycles; `NbEff`=254 with a high time of 37338 cycles. `Nb`=6 and `Nb`=254 pass through unclamped.
- `Start` re-asserted at cycles 5, 500 and 1550 of a `Nb`=10 sequence, `Nb` changed to 200 mid-pulse -> all ignored; high time stays 1470; exactly one `Done`.
- `Rst` asserted at cycle 700 of a `Nb`=10 sequence -> `Mesure`=0 and `Busy`=0 from cycle 701; no `Done`; a new `Start` at cycle 710 yields a normal sequence.
- `Start` held high continuously with `Nb`=20 -> second sequence accepted in the `Done` cycle; rising edges exactly 3021 cycles apart (16 + 2940 + 64 + 1).
- Loopback into the echo-width counter for `Nb` in {6, 7, 100, 253, 254} -> the counter output equals `NbEff` every time.
